// File: rtl/sram_fb_reader.sv
// Raster-order framebuffer reader: fetches one pixel per two-cycle async SRAM
// read starting at BASE_ADDR and streams the words out through a small FIFO.
module sram_fb_reader #(
    parameter int                   ADDR_BITS  = 20,
    parameter int                   DATA_BITS  = 16,
    parameter int                   PIXEL_BITS = 12,
    parameter int                   H_VISIBLE  = 640,
    parameter int                   V_VISIBLE  = 480,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR  = {ADDR_BITS{1'b0}},
    parameter int                   FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  frame_start,
    output logic [ADDR_BITS-1:0]  sram_io_addr,
    input  logic [DATA_BITS-1:0]  sram_io_data,
    output logic                  sram_io_we_n,
    output logic                  sram_io_oe_n,
    output logic                  sram_io_ce_n,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic [PIXEL_BITS-1:0] pixel_data,
    output logic                  pixel_last
);

    localparam int NUM_PIXELS = H_VISIBLE * V_VISIBLE;
    localparam int IDX_BITS   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = PTR_BITS + 1;
    localparam int ENTRY_BITS = PIXEL_BITS + 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_PIXELS - 1);
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [IDX_BITS-1:0]     idx_r, idx_nxt_s;
    logic [ADDR_BITS-1:0]    fetch_addr_r, fetch_addr_nxt_s;
    logic [ADDR_BITS-1:0]    addr_r;
    logic                    ce_n_r, oe_n_r;
    logic [ENTRY_BITS-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_BITS-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_BITS-1:0]     count_r;
    logic [CNT_BITS-1:0]     pending_s;
    logic                    inflight_s, issue_ok_s, push_s, pop_s, is_last_s;
    logic                    data_unused_s;

    assign data_unused_s = ^sram_io_data[DATA_BITS-1:PIXEL_BITS];

    // Issue gating: a read may start only if its word is guaranteed a FIFO slot.
    always_comb begin
        inflight_s = (state_r == ST_ADDR) || (state_r == ST_DATA);
        pending_s  = count_r + {{(CNT_BITS-1){1'b0}}, inflight_s};
        issue_ok_s = enable && (pending_s < DEPTH_CNT);
        push_s     = (state_r == ST_DATA) && !frame_start;
        pop_s      = (count_r != {CNT_BITS{1'b0}}) && pixel_ready && !frame_start;
        is_last_s  = (idx_r == LAST_IDX);
    end

    // Read sequencer next state; frame_start overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (frame_start) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = issue_ok_s ? ST_ADDR : ST_IDLE;
                ST_ADDR: state_nxt_s = ST_DATA;
                ST_DATA: state_nxt_s = issue_ok_s ? ST_ADDR : ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Pixel index and matching SRAM address advance together, no multiplier.
    always_comb begin
        idx_nxt_s        = idx_r;
        fetch_addr_nxt_s = fetch_addr_r;
        if (frame_start) begin
            idx_nxt_s        = {IDX_BITS{1'b0}};
            fetch_addr_nxt_s = BASE_ADDR;
        end else if (push_s) begin
            if (is_last_s) begin
                idx_nxt_s        = {IDX_BITS{1'b0}};
                fetch_addr_nxt_s = BASE_ADDR;
            end else begin
                idx_nxt_s        = idx_r + IDX_BITS'(1);
                fetch_addr_nxt_s = fetch_addr_r + ADDR_BITS'(1);
            end
        end else begin
            idx_nxt_s        = idx_r;
            fetch_addr_nxt_s = fetch_addr_r;
        end
    end

    // State and index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_BITS{1'b0}};
            fetch_addr_r <= BASE_ADDR;
        end else begin
            state_r      <= state_nxt_s;
            idx_r        <= idx_nxt_s;
            fetch_addr_r <= fetch_addr_nxt_s;
        end
    end

    // SRAM pins are registered from the next state so they only move on ADDR entry or return to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= {ADDR_BITS{1'b0}};
            ce_n_r <= 1'b1;
            oe_n_r <= 1'b1;
        end else begin
            if (state_nxt_s == ST_ADDR) begin
                addr_r <= fetch_addr_nxt_s;
            end else begin
                addr_r <= addr_r;
            end
            ce_n_r <= (state_nxt_s == ST_IDLE);
            oe_n_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Output FIFO: storage, pointers and occupancy; flushed by frame_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {ENTRY_BITS{1'b0}};
            end
            wr_ptr_r <= {PTR_BITS{1'b0}};
            rd_ptr_r <= {PTR_BITS{1'b0}};
            count_r  <= {CNT_BITS{1'b0}};
        end else if (frame_start) begin
            wr_ptr_r <= {PTR_BITS{1'b0}};
            rd_ptr_r <= {PTR_BITS{1'b0}};
            count_r  <= {CNT_BITS{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {is_last_s, sram_io_data[PIXEL_BITS-1:0]};
                wr_ptr_r             <= wr_ptr_r + PTR_BITS'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_BITS'(1);
                2'b01:   count_r <= count_r - CNT_BITS'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign sram_io_addr = addr_r;
    assign sram_io_we_n = 1'b1;
    assign sram_io_oe_n = oe_n_r;
    assign sram_io_ce_n = ce_n_r;
    assign pixel_valid  = (count_r != {CNT_BITS{1'b0}});
    assign pixel_data   = fifo_mem_r[rd_ptr_r][PIXEL_BITS-1:0];
    assign pixel_last   = fifo_mem_r[rd_ptr_r][PIXEL_BITS];

endmodule
